// File: rtl/parity_generator_tx.sv
// parity_generator_tx
//   Transmit-side companion of the 64-bit parity checker. Words arrive over a
//   valid/ready handshake. Even and odd parity are computed when a word is
//   enqueued and stored with it in a small FIFO. The head entry is presented
//   to the link over a second valid/ready port.
//
//   Optional feature macro: PARITY_TX_ERR_INJECT_EN
//     When it is defined, the block gains an injectErr input. When injectErr
//     is high during an accepted push, both stored parity bits are inverted.
//
// Ports
//   clk, reset         single rising-edge clock, asynchronous active-high reset
//   inData/inValid     word to transmit and its valid flag
//   inReady            FIFO has a free entry (fillCount < DEPTH)
//   injectErr          (macro only) corrupt parity of the word being pushed
//   txData             head-of-FIFO word
//   txEvenParity       stored ^word   (ones count including this bit is even)
//   txOddParity        stored ~^word  (ones count including this bit is odd)
//   txValid/txReady    FIFO non-empty / downstream accepts
//   fillCount          current occupancy, 0..DEPTH
//   sentCount          words popped since reset, wraps silently
module parity_generator_tx #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   inData,
  input  logic                    inValid,
`ifdef PARITY_TX_ERR_INJECT_EN
  input  logic                    injectErr,
`endif
  output logic                    inReady,
  output logic [DATA_WIDTH-1:0]   txData,
  output logic                    txEvenParity,
  output logic                    txOddParity,
  output logic                    txValid,
  input  logic                    txReady,
  output logic [$clog2(DEPTH):0]  fillCount,
  output logic [CNT_WIDTH-1:0]    sentCount
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] dataMem [DEPTH];
  logic                  evenMem [DEPTH];
  logic                  oddMem  [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  logic pushEn_c;
  logic popEn_c;
  logic evenBit_c;
  logic oddBit_c;

  // Handshake decode; status flags come straight from the occupancy register.
  assign inReady  = (fillCount != FILL_W'(DEPTH));
  assign txValid  = (fillCount != FILL_W'(0));
  assign pushEn_c = inValid & inReady;
  assign popEn_c  = txValid & txReady;

  // Parity of the incoming word, optionally inverted for error injection.
`ifdef PARITY_TX_ERR_INJECT_EN
  assign evenBit_c = (^inData)  ^ injectErr;
  assign oddBit_c  = (~^inData) ^ injectErr;
`else
  assign evenBit_c = ^inData;
  assign oddBit_c  = ~^inData;
`endif

  // Head entry drives the link; parity is read back as stored, never recomputed.
  assign txData       = dataMem[rdPtr];
  assign txEvenParity = evenMem[rdPtr];
  assign txOddParity  = oddMem[rdPtr];

  // FIFO storage, pointers and counters. Reset clears every entry so the
  // output port shows data=0, even=0, odd=1 while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fillCount <= '0;
      sentCount <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dataMem[i] <= '0;
        evenMem[i] <= 1'b0;
        oddMem[i]  <= 1'b1;
      end
    end else begin
      if (pushEn_c) begin
        dataMem[wrPtr] <= inData;
        evenMem[wrPtr] <= evenBit_c;
        oddMem[wrPtr]  <= oddBit_c;
        wrPtr          <= wrPtr + PTR_W'(1);
      end
      if (popEn_c) begin
        rdPtr     <= rdPtr + PTR_W'(1);
        sentCount <= sentCount + CNT_WIDTH'(1);
      end
      if (pushEn_c && !popEn_c) begin
        fillCount <= fillCount + FILL_W'(1);
      end else if (!pushEn_c && popEn_c) begin
        fillCount <= fillCount - FILL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_generator_tx.sv
// Self-checking bench for parity_generator_tx: a directed table of
// transactions with hand-derived expectations, a reset-while-buffered
// sequence, then random traffic checked against a queue-based model.
module tb_parity_generator_tx;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned FW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] txData;
  logic          txEvenParity;
  logic          txOddParity;
  logic          txValid;
  logic          txReady;
  logic [FW-1:0] fillCount;
  logic [CW-1:0] sentCount;
`ifdef PARITY_TX_ERR_INJECT_EN
  logic          injectErr = 1'b0;
`endif

  parity_generator_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .inData(inData),
    .inValid(inValid),
`ifdef PARITY_TX_ERR_INJECT_EN
    .injectErr(injectErr),
`endif
    .inReady(inReady),
    .txData(txData),
    .txEvenParity(txEvenParity),
    .txOddParity(txOddParity),
    .txValid(txValid),
    .txReady(txReady),
    .fillCount(fillCount),
    .sentCount(sentCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the FIFO contents as a queue plus a pop counter.
  logic [DW-1:0] modelQ[$];
  int unsigned   modelSent = 0;

  typedef struct {
    logic          vld;
    logic [DW-1:0] data;
    logic          rdy;
    logic          expValid;
    logic [DW-1:0] expData;
    logic          expEven;
    logic          expOdd;
    int unsigned   expFill;
    int unsigned   expSent;
    logic          expInReady;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Parity from a ones count: even bit set when the word has an odd number of ones.
  function automatic logic refEven(input logic [DW-1:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  function automatic logic refOdd(input logic [DW-1:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Apply inputs for one clock, then advance the model by the same edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    bit push;
    bit pop;
    inValid = v;
    inData  = d;
    txReady = r;
    push = v && (modelQ.size() < DEPTH);
    pop  = r && (modelQ.size() > 0);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(modelQ.pop_front());
      modelSent = (modelSent + 1) % (1 << CW);
    end
    if (push) modelQ.push_back(d);
  endtask

  task automatic checkModel(input string tag);
    logic [DW-1:0] head;
    chk({tag, ".txValid"},   DW'(txValid),   DW'(modelQ.size() != 0));
    chk({tag, ".fillCount"}, DW'(fillCount), DW'(modelQ.size()));
    chk({tag, ".inReady"},   DW'(inReady),   DW'(modelQ.size() < DEPTH));
    chk({tag, ".sentCount"}, DW'(sentCount), DW'(modelSent));
    if (modelQ.size() != 0) begin
      head = modelQ[0];
      chk({tag, ".txData"}, txData, head);
      chk({tag, ".even"},   DW'(txEvenParity), DW'(refEven(head)));
      chk({tag, ".odd"},    DW'(txOddParity),  DW'(refOdd(head)));
    end
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, ".txValid"},   DW'(txValid),      DW'(0));
    chk({tag, ".inReady"},   DW'(inReady),      DW'(1));
    chk({tag, ".txData"},    txData,            DW'(0));
    chk({tag, ".even"},      DW'(txEvenParity), DW'(0));
    chk({tag, ".odd"},       DW'(txOddParity),  DW'(1));
    chk({tag, ".fillCount"}, DW'(fillCount),    DW'(0));
    chk({tag, ".sentCount"}, DW'(sentCount),    DW'(0));
  endtask

  initial begin
    logic [DW-1:0] wA, wB, wC, wD, wE, wF;
    wA = 64'h3;                       // 2 ones
    wB = 64'h7;                       // 3 ones
    wC = 64'h8000_0000_0000_0000;     // 1 one
    wD = 64'hA5A5_A5A5_A5A5_A5A5;     // 32 ones
    wE = 64'h0123_4567_89AB_CDEF;     // 32 ones
    wF = 64'hFFFF_FFFF_FFFF_FFFF;     // 64 ones

    //            vld   data   rdy   valid expData even  odd  fill sent inRdy
    tbl[0]  = '{1'b1, 64'h0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b1, 1, 0, 1'b1};
    tbl[1]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 0, 1, 1'b1};
    tbl[2]  = '{1'b1, 64'h1, 1'b1, 1'b1, 64'h1, 1'b1, 1'b0, 1, 1, 1'b1};
    tbl[3]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 0, 2, 1'b1};
    tbl[4]  = '{1'b1, wA,    1'b0, 1'b1, wA,    1'b0, 1'b1, 1, 2, 1'b1};
    tbl[5]  = '{1'b1, wB,    1'b0, 1'b1, wA,    1'b0, 1'b1, 2, 2, 1'b1};
    tbl[6]  = '{1'b1, wC,    1'b0, 1'b1, wA,    1'b0, 1'b1, 3, 2, 1'b1};
    tbl[7]  = '{1'b1, wD,    1'b0, 1'b1, wA,    1'b0, 1'b1, 4, 2, 1'b0};
    tbl[8]  = '{1'b1, wE,    1'b0, 1'b1, wA,    1'b0, 1'b1, 4, 2, 1'b0};
    tbl[9]  = '{1'b1, wE,    1'b1, 1'b1, wB,    1'b1, 1'b0, 3, 3, 1'b1};
    tbl[10] = '{1'b1, wE,    1'b1, 1'b1, wC,    1'b1, 1'b0, 3, 4, 1'b1};
    tbl[11] = '{1'b0, 64'h0, 1'b1, 1'b1, wD,    1'b0, 1'b1, 2, 5, 1'b1};
    tbl[12] = '{1'b1, wF,    1'b1, 1'b1, wE,    1'b0, 1'b1, 2, 6, 1'b1};
    tbl[13] = '{1'b0, 64'h0, 1'b1, 1'b1, wF,    1'b0, 1'b1, 1, 7, 1'b1};
    tbl[14] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 0, 8, 1'b1};

    inValid = 1'b0;
    inData  = '0;
    txReady = 1'b0;
    reset   = 1'b1;
    #2;
    checkResetValues("initReset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed transactions: empty latency, single pop, fill/hold, push+pop at mid fill.
    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(tbl[i].vld, tbl[i].data, tbl[i].rdy);
      chk({tag, ".txValid"},   DW'(txValid),   DW'(tbl[i].expValid));
      chk({tag, ".fillCount"}, DW'(fillCount), DW'(tbl[i].expFill));
      chk({tag, ".sentCount"}, DW'(sentCount), DW'(tbl[i].expSent));
      chk({tag, ".inReady"},   DW'(inReady),   DW'(tbl[i].expInReady));
      if (tbl[i].expValid) begin
        chk({tag, ".txData"}, txData, tbl[i].expData);
        chk({tag, ".even"},   DW'(txEvenParity), DW'(tbl[i].expEven));
        chk({tag, ".odd"},    DW'(txOddParity),  DW'(tbl[i].expOdd));
      end
    end

    // Asynchronous reset with three words buffered: outputs clear without an edge.
    cycle(1'b1, 64'h1111, 1'b0);
    cycle(1'b1, 64'h2222, 1'b0);
    cycle(1'b1, 64'h3333, 1'b0);
    checkModel("preReset");
    inValid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checkResetValues("asyncReset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelQ.delete();
    modelSent = 0;
    checkModel("postReset");

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      logic          v;
      logic          r;
      logic [DW-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 15) == 0) d = '0;
      if ($urandom_range(0, 15) == 0) d = '1;
      cycle(v, d, r);
      checkModel($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
